// File: rtl/bec_la_bridge.sv
// LA command bridge for the binary Edwards curve core: operand load, start,
// status and result readback over the management logic-analyzer bus.
module bec_la_bridge #(
    parameter int FIELD_W = 163,
    parameter int WORD_W  = 32,
    parameter int WORDS   = 6,
    parameter int N_OPS   = 6,
    parameter int N_RES   = 4
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    input  logic [127:0]               la_data_in,
    input  logic [127:0]               la_oenb,
    output logic [127:0]               la_data_out,
    output logic [N_OPS*FIELD_W-1:0]   bec_ops,
    output logic                       bec_start,
    input  logic [N_RES*FIELD_W-1:0]   bec_res,
    input  logic                       bec_done
);

    localparam int OPS_W    = N_OPS * FIELD_W;
    localparam int RES_W    = N_RES * FIELD_W;
    localparam int MASK_W   = N_OPS * WORDS;
    localparam int TOP_BITS = FIELD_W - (WORDS - 1) * WORD_W;
    localparam logic [WORD_W-1:0] TOP_MASK = {WORD_W{1'b1}} >> (WORD_W - TOP_BITS);

    localparam logic [1:0] CMD_CLEAR = 2'b00;
    localparam logic [1:0] CMD_WRITE = 2'b01;
    localparam logic [1:0] CMD_START = 2'b10;
    localparam logic [1:0] CMD_READ  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_RUN  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    state_t              state_q, state_d;
    logic [OPS_W-1:0]    ops_q, ops_d;
    logic [RES_W-1:0]    res_q, res_d;
    logic [MASK_W-1:0]   mask_q, mask_d;
    logic [31:0]         cnt_q, cnt_d;
    logic [WORD_W-1:0]   rdata_q, rdata_d;
    logic [7:0]          ack_q, ack_d;
    logic                err_q, err_d;
    logic                done_q, done_d;
    logic                start_q, start_d;
    logic                strb_q, strb_d;

    // Inputs not driven by management (oenb=1) read as zero.
    logic [41:0]         la_in;
    logic [WORD_W-1:0]   wdata;
    logic [1:0]          cmd;
    int                  sel_i;
    int                  idx_i;
    logic                cmd_evt;
    logic [WORD_W-1:0]   word_mask;
    logic [OPS_W-1:0]    wr_bits;
    logic [OPS_W-1:0]    wr_keep;
    logic [WORD_W-1:0]   rd_word;
    logic                unused_ok;

    assign la_in     = la_data_in[41:0] & ~la_oenb[41:0];
    assign wdata     = la_in[31:0];
    assign cmd       = la_in[41:40];
    assign sel_i     = int'(la_in[34:32]);
    assign idx_i     = int'(la_in[37:35]);
    assign cmd_evt   = la_data_in[42] & ~strb_q & ~la_oenb[42];
    assign unused_ok = &{1'b0, la_in[39:38], la_data_in[127:43], la_oenb[127:43]};

    assign word_mask = (idx_i == WORDS - 1) ? TOP_MASK : {WORD_W{1'b1}};

    // Word placement by shifting keeps the top word from spilling into the next operand.
    assign wr_bits = {{(OPS_W - WORD_W){1'b0}}, wdata & word_mask} << (sel_i * FIELD_W + idx_i * WORD_W);
    assign wr_keep = {{(OPS_W - WORD_W){1'b0}}, word_mask} << (sel_i * FIELD_W + idx_i * WORD_W);
    assign rd_word = WORD_W'(res_q >> (sel_i * FIELD_W + idx_i * WORD_W)) & word_mask;

    always_comb begin
        state_d = state_q;
        ops_d   = ops_q;
        res_d   = res_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        ack_d   = ack_q;
        err_d   = err_q;
        done_d  = done_q;
        start_d = 1'b0;
        strb_d  = la_data_in[42];

        if (state_q == ST_RUN) begin
            if (cnt_q != 32'hFFFF_FFFF) begin
                cnt_d = cnt_q + 32'd1;
            end
            if (bec_done) begin
                res_d   = bec_res;
                state_d = ST_DONE;
                done_d  = 1'b1;
            end
        end

        // Commands are judged against the pre-edge state, even when bec_done lands together.
        if (cmd_evt) begin
            ack_d = ack_q + 8'd1;
            case (cmd)
                CMD_CLEAR: begin
                    if (state_q != ST_RUN) begin
                        err_d  = 1'b0;
                        done_d = 1'b0;
                        mask_d = '0;
                    end
                end
                CMD_WRITE: begin
                    if (state_q == ST_RUN || sel_i >= N_OPS || idx_i >= WORDS) begin
                        err_d = 1'b1;
                    end else begin
                        ops_d = (ops_q & ~wr_keep) | wr_bits;
                        mask_d[sel_i * WORDS + idx_i] = 1'b1;
                        if (state_q == ST_IDLE || state_q == ST_DONE) begin
                            state_d = ST_LOAD;
                        end
                    end
                end
                CMD_START: begin
                    if (state_q == ST_RUN || mask_q != {MASK_W{1'b1}}) begin
                        err_d = 1'b1;
                    end else begin
                        start_d = 1'b1;
                        cnt_d   = '0;
                        err_d   = 1'b0;
                        done_d  = 1'b0;
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    if (state_q == ST_RUN || idx_i >= WORDS) begin
                        err_d = 1'b1;
                    end else if (sel_i == 7) begin
                        rdata_d = cnt_q;
                    end else if (sel_i < N_RES) begin
                        rdata_d = rd_word;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            ops_q   <= '0;
            res_q   <= '0;
            mask_q  <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            ack_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            start_q <= 1'b0;
            strb_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ops_q   <= ops_d;
            res_q   <= res_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            done_q  <= done_d;
            start_q <= start_d;
            strb_q  <= strb_d;
        end
    end

    assign bec_ops   = ops_q;
    assign bec_start = start_q;

    always_comb begin
        la_data_out        = '0;
        la_data_out[31:0]  = rdata_q;
        la_data_out[33:32] = state_q;
        la_data_out[34]    = (state_q == ST_RUN);
        la_data_out[35]    = done_q;
        la_data_out[36]    = err_q;
        la_data_out[47:40] = ack_q;
    end

endmodule

// File: tb/tb_bec_la_bridge.sv
// Directed self-checking bench for bec_la_bridge: load, start, completion,
// error paths, strobe edge detection, oenb masking, ack wrap and reset mid-run.
module tb_bec_la_bridge;

    localparam int FIELD_W = 163;
    localparam int WORD_W  = 32;
    localparam int WORDS   = 6;
    localparam int N_OPS   = 6;
    localparam int N_RES   = 4;

    logic                      wb_clk_i = 1'b0;
    logic                      wb_rst_i = 1'b1;
    logic [127:0]              la_data_in = '0;
    logic [127:0]              la_oenb = '0;
    logic [127:0]              la_data_out;
    logic [N_OPS*FIELD_W-1:0]  bec_ops;
    logic                      bec_start;
    logic [N_RES*FIELD_W-1:0]  bec_res = '0;
    logic                      bec_done = 1'b0;

    int         errors = 0;
    int         checks = 0;
    int         start_cnt = 0;
    logic [7:0] exp_ack = '0;
    logic [162:0] top_only;

    bec_la_bridge #(
        .FIELD_W(FIELD_W), .WORD_W(WORD_W), .WORDS(WORDS), .N_OPS(N_OPS), .N_RES(N_RES)
    ) dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .la_data_in (la_data_in),
        .la_oenb    (la_oenb),
        .la_data_out(la_data_out),
        .bec_ops    (bec_ops),
        .bec_start  (bec_start),
        .bec_res    (bec_res),
        .bec_done   (bec_done)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    always @(posedge wb_clk_i) begin
        if (bec_start === 1'b1) start_cnt <= start_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic la_cmd(input logic [1:0] cmd, input logic [2:0] sel, input logic [2:0] idx,
                          input logic [31:0] wd, input logic dn = 1'b0);
        @(negedge wb_clk_i);
        la_data_in         = '0;
        la_data_in[31:0]   = wd;
        la_data_in[34:32]  = sel;
        la_data_in[37:35]  = idx;
        la_data_in[41:40]  = cmd;
        la_data_in[42]     = 1'b1;
        bec_done           = dn;
        if (la_oenb[42] == 1'b0) exp_ack++;
        @(negedge wb_clk_i);
        la_data_in[42] = 1'b0;
        bec_done       = 1'b0;
    endtask

    function automatic logic [31:0] pat(input int s, input int i);
        return 32'hA000_0000 | 32'(s << 4) | 32'(i);
    endfunction

    initial begin
        top_only = '0;
        top_only[162:160] = 3'b111;

        // Reset
        repeat (3) @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        chk("rst_la_out", 64'(la_data_out == '0), 64'd1);
        chk("rst_ops", 64'(bec_ops == '0), 64'd1);
        chk("rst_start", 64'(bec_start), 64'd0);

        // Full load: only word 5 all-ones, so every element is 3'b111 at the top
        la_cmd(2'b01, 3'd0, 3'd0, 32'h0);
        chk("first_write_state", 64'(la_data_out[33:32]), 64'd1);
        for (int s = 0; s < N_OPS; s++) begin
            for (int i = 0; i < WORDS; i++) begin
                if (!(s == 0 && i == 0)) la_cmd(2'b01, 3'(s), 3'(i), (i == 5) ? 32'hFFFF_FFFF : 32'h0);
            end
        end
        for (int s = 0; s < N_OPS; s++) begin
            chk($sformatf("op%0d_top_only", s), 64'(bec_ops[s*FIELD_W +: FIELD_W] == top_only), 64'd1);
        end
        chk("load_ack", 64'(la_data_out[47:40]), 64'd36);
        chk("load_state", 64'(la_data_out[33:32]), 64'd1);
        chk("load_err", 64'(la_data_out[36]), 64'd0);

        // Start and model completion 1000 cycles later
        bec_res = '0;
        bec_res[0 +: FIELD_W] = 163'd1;
        bec_res[3*FIELD_W +: FIELD_W] = '1;
        la_cmd(2'b10, 3'd0, 3'd0, 32'h0);
        chk("start_pulse", 64'(bec_start), 64'd1);
        chk("run_state", 64'(la_data_out[33:32]), 64'd2);
        chk("run_busy", 64'(la_data_out[34]), 64'd1);
        @(negedge wb_clk_i);
        chk("start_one_cycle", 64'(bec_start), 64'd0);
        repeat (998) @(negedge wb_clk_i);
        bec_done = 1'b1;
        @(negedge wb_clk_i);
        bec_done = 1'b0;
        chk("done_state", 64'(la_data_out[33:32]), 64'd3);
        chk("done_flag", 64'(la_data_out[35]), 64'd1);
        chk("done_busy", 64'(la_data_out[34]), 64'd0);
        la_cmd(2'b11, 3'd7, 3'd0, 32'h0);
        chk("cyc_cnt_1000pm1", 64'(la_data_out[31:0] >= 32'd999 && la_data_out[31:0] <= 32'd1001), 64'd1);
        la_cmd(2'b11, 3'd0, 3'd0, 32'h0);
        chk("res0_w0", 64'(la_data_out[31:0]), 64'h1);
        la_cmd(2'b11, 3'd1, 3'd0, 32'h0);
        chk("res1_w0", 64'(la_data_out[31:0]), 64'h0);
        la_cmd(2'b11, 3'd3, 3'd4, 32'h0);
        chk("res3_w4", 64'(la_data_out[31:0]), 64'hFFFF_FFFF);
        la_cmd(2'b11, 3'd3, 3'd5, 32'h0);
        chk("res3_w5_zext", 64'(la_data_out[31:0]), 64'h7);
        chk("reads_no_err", 64'(la_data_out[36]), 64'd0);

        // Error paths
        la_cmd(2'b00, 3'd0, 3'd0, 32'h0);
        chk("clear_done", 64'(la_data_out[35]), 64'd0);
        la_cmd(2'b11, 3'd5, 3'd0, 32'h0);
        chk("read_bad_sel_err", 64'(la_data_out[36]), 64'd1);
        chk("read_bad_sel_hold", 64'(la_data_out[31:0]), 64'h7);
        la_cmd(2'b00, 3'd0, 3'd0, 32'h0);
        chk("clear_err", 64'(la_data_out[36]), 64'd0);
        la_cmd(2'b01, 3'd6, 3'd0, 32'h1234);
        chk("write_bad_sel_err", 64'(la_data_out[36]), 64'd1);
        chk("write_bad_sel_state", 64'(la_data_out[33:32]), 64'd3);
        la_cmd(2'b00, 3'd0, 3'd0, 32'h0);
        la_cmd(2'b01, 3'd0, 3'd6, 32'h1234);
        chk("write_bad_idx_err", 64'(la_data_out[36]), 64'd1);
        chk("write_bad_idx_ops", 64'(bec_ops[0 +: FIELD_W] == top_only), 64'd1);
        la_cmd(2'b00, 3'd0, 3'd0, 32'h0);
        la_cmd(2'b11, 3'd0, 3'd6, 32'h0);
        chk("read_bad_idx_err", 64'(la_data_out[36]), 64'd1);
        la_cmd(2'b00, 3'd0, 3'd0, 32'h0);

        // Partial load: one word missing
        for (int s = 0; s < N_OPS; s++) begin
            for (int i = 0; i < WORDS; i++) begin
                if (!(s == 2 && i == 3)) la_cmd(2'b01, 3'(s), 3'(i), pat(s, i));
            end
        end
        chk("partial_state", 64'(la_data_out[33:32]), 64'd1);
        la_cmd(2'b10, 3'd0, 3'd0, 32'h0);
        chk("partial_start_err", 64'(la_data_out[36]), 64'd1);
        chk("partial_start_state", 64'(la_data_out[33:32]), 64'd1);
        chk("partial_no_pulse", 64'(start_cnt), 64'd1);
        la_cmd(2'b00, 3'd0, 3'd0, 32'h0);
        chk("clear_err2", 64'(la_data_out[36]), 64'd0);
        la_cmd(2'b01, 3'd2, 3'd3, pat(2, 3));
        la_cmd(2'b10, 3'd0, 3'd0, 32'h0);
        chk("clear_mask_err", 64'(la_data_out[36]), 64'd1);
        la_cmd(2'b00, 3'd0, 3'd0, 32'h0);
        for (int s = 0; s < N_OPS; s++) begin
            for (int i = 0; i < WORDS; i++) la_cmd(2'b01, 3'(s), 3'(i), pat(s, i));
        end
        chk("op2_w3", 64'(bec_ops[2*FIELD_W + 3*WORD_W +: WORD_W]), 64'hA000_0023);
        chk("op1_top", 64'(bec_ops[FIELD_W + 160 +: 3]), 64'd5);
        chk("op0_w0", 64'(bec_ops[0 +: WORD_W]), 64'hA000_0000);

        // Run A: READ coincident with bec_done
        bec_res[0 +: FIELD_W] = 163'h55;
        la_cmd(2'b10, 3'd0, 3'd0, 32'h0);
        chk("runA_err_cleared", 64'(la_data_out[36]), 64'd0);
        chk("runA_state", 64'(la_data_out[33:32]), 64'd2);
        @(negedge wb_clk_i);
        chk("runA_pulses", 64'(start_cnt), 64'd2);
        la_cmd(2'b11, 3'd0, 3'd0, 32'h0, 1'b1);
        chk("runA_done_state", 64'(la_data_out[33:32]), 64'd3);
        chk("runA_read_err", 64'(la_data_out[36]), 64'd1);
        chk("runA_done_flag", 64'(la_data_out[35]), 64'd1);
        chk("runA_rdata_hold", 64'(la_data_out[31:0]), 64'h7);
        la_cmd(2'b11, 3'd0, 3'd0, 32'h0);
        chk("runA_res0", 64'(la_data_out[31:0]), 64'h55);

        // Run B: WRITE, START and CLEAR while running
        la_cmd(2'b10, 3'd0, 3'd0, 32'h0);
        chk("runB_err_cleared", 64'(la_data_out[36]), 64'd0);
        la_cmd(2'b01, 3'd0, 3'd0, 32'hDEAD_BEEF);
        chk("runB_write_err", 64'(la_data_out[36]), 64'd1);
        chk("runB_ops_kept", 64'(bec_ops[0 +: WORD_W]), 64'hA000_0000);
        la_cmd(2'b10, 3'd0, 3'd0, 32'h0);
        chk("runB_state", 64'(la_data_out[33:32]), 64'd2);
        @(negedge wb_clk_i);
        chk("runB_no_restart", 64'(start_cnt), 64'd3);
        la_cmd(2'b00, 3'd0, 3'd0, 32'h0);
        chk("runB_clear_ignored", 64'(la_data_out[36]), 64'd1);
        @(negedge wb_clk_i);
        bec_done = 1'b1;
        @(negedge wb_clk_i);
        bec_done = 1'b0;
        chk("runB_done_state", 64'(la_data_out[33:32]), 64'd3);

        // Strobe held high for 10 cycles
        @(negedge wb_clk_i);
        la_data_in = '0;
        la_data_in[41:40] = 2'b11;
        la_data_in[34:32] = 3'd7;
        la_data_in[42] = 1'b1;
        exp_ack++;
        repeat (10) @(negedge wb_clk_i);
        la_data_in[42] = 1'b0;
        @(negedge wb_clk_i);
        chk("held_strobe_ack", 64'(la_data_out[47:40]), 64'(exp_ack));

        // oenb masking
        la_oenb[42] = 1'b1;
        la_cmd(2'b01, 3'd0, 3'd0, 32'h1234_5678);
        la_oenb = '0;
        chk("oenb_strb_ack", 64'(la_data_out[47:40]), 64'(exp_ack));
        chk("oenb_strb_ops", 64'(bec_ops[0 +: WORD_W]), 64'hA000_0000);
        chk("oenb_strb_state", 64'(la_data_out[33:32]), 64'd3);
        la_oenb[31:0] = '1;
        la_cmd(2'b01, 3'd0, 3'd0, 32'hFFFF_FFFF);
        la_oenb = '0;
        chk("oenb_data_zero", 64'(bec_ops[0 +: WORD_W]), 64'h0);
        chk("oenb_data_state", 64'(la_data_out[33:32]), 64'd1);

        // ack_cnt wrap
        while (exp_ack != 8'd0) la_cmd(2'b11, 3'd7, 3'd0, 32'h0);
        chk("ack_wrap", 64'(la_data_out[47:40]), 64'd0);

        // Reset during RUN, then a stray bec_done
        la_cmd(2'b10, 3'd0, 3'd0, 32'h0);
        chk("rstrun_state", 64'(la_data_out[33:32]), 64'd2);
        wb_rst_i = 1'b1;
        repeat (2) @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        exp_ack = '0;
        bec_res = '1;
        bec_done = 1'b1;
        @(negedge wb_clk_i);
        bec_done = 1'b0;
        chk("rstrun_la_out", 64'(la_data_out == '0), 64'd1);
        chk("rstrun_ops", 64'(bec_ops == '0), 64'd1);
        la_cmd(2'b11, 3'd0, 3'd0, 32'h0);
        chk("rstrun_res0", 64'(la_data_out[31:0]), 64'h0);
        la_cmd(2'b11, 3'd3, 3'd5, 32'h0);
        chk("rstrun_res3", 64'(la_data_out[31:0]), 64'h0);
        chk("rstrun_idle", 64'(la_data_out[33:32]), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bec_la_bridge.md
Name: bec_la_bridge

Overview:
- Bridge between the management SoC's logic analyzer (LA) bus and the binary Edwards curve (BEC) point-arithmetic core, inside the user project.
- Firmware uses LA command words to write GF(2^m) operands word-by-word, start the core, poll status and read results back.
- It is the block directly upstream and downstream of the BEC core and implements the "write data / processing / done / results" flow that firmware reports on the checkbits GPIOs.

Parameters:
- FIELD_W, 163, field element width in bits.
- WORD_W, 32, LA data word width.
- WORDS, 6, words per element; equals ceil(FIELD_W/WORD_W).
- N_OPS, 6, input operands: 0=key, 1=w1, 2=z1, 3=w2, 4=z2, 5=d.
- N_RES, 4, result elements: 0=w1, 1=z1, 2=w2, 3=z2.

Ports:
- wb_clk_i  in  1  system clock.
- wb_rst_i  in  1  synchronous, active-high reset.
- la_data_in  in  128  LA from management. [31:0] wdata, [34:32] sel, [37:35] word idx, [41:40] cmd, [42] strobe.
- la_oenb  in  128  LA output-enable bar. A bit is valid input only when its oenb bit is 0.
- la_data_out  out  128  LA to management. [31:0] rdata, [33:32] state, [34] busy, [35] done, [36] err, [47:40] ack_cnt, all other bits 0.
- bec_ops  out  N_OPS*FIELD_W  operand registers, operand k at [k*FIELD_W +: FIELD_W].
- bec_start  out  1  one-cycle start pulse to the core.
- bec_res  in  N_RES*FIELD_W  core results, same packing as bec_ops.
- bec_done  in  1  one-cycle completion pulse from the core.

Behaviour:
- Reset: all outputs 0, including operand regs, result regs, written mask, cycle counter, ack_cnt, err, done and state.
- Command event:
  - strb_q registers la_data_in[42].
  - An event fires in cycle N when la_data_in[42]=1, strb_q=0 and la_oenb[42]=0.
  - Its effect is registered at the clock edge ending cycle N.
  - Every event increments ack_cnt (8-bit, wraps 255->0).
  - A strobe held high produces one event only.
- cmd 00 CLEAR: clears err, done and the written mask. Operand regs are untouched. Ignored in RUN.
- cmd 01 WRITE:
  - Loads wdata into operand sel, word idx, and sets mask bit [sel*WORDS+idx].
  - Word idx covers bits [idx*32 +: 32]. For the top word, only bits up to FIELD_W-1 are stored; the rest are discarded.
  - sel >= N_OPS or idx >= WORDS: err=1, no write.
  - In RUN: err=1, no write.
- cmd 10 START:
  - Requires state IDLE or DONE and the full mask (all N_OPS*WORDS bits).
  - On acceptance: bec_start=1 for exactly the next cycle, cycle counter cleared, err and done cleared, state -> RUN.
  - Incomplete mask: err=1, state unchanged.
  - In RUN: err=1, no second start.
- cmd 11 READ:
  - sel < N_RES: rdata = result sel, word idx, zero-extended above FIELD_W.
  - sel = 7: rdata = cycle counter.
  - rdata updates the cycle after the event and holds until the next READ.
  - Other sel or idx >= WORDS: err=1, rdata unchanged.
  - In RUN: err=1.
- States (encoding on la_data_out[33:32]):
  - 00 IDLE
  - 01 LOAD: entered on the first accepted WRITE.
  - 10 RUN: busy=1, counter +1 per cycle, saturating at 2^32-1.
  - 11 DONE
- Transitions:
  - bec_done in RUN latches all bec_res into result regs on that edge; state -> DONE, done=1.
  - bec_done outside RUN is ignored.
  - From DONE, a WRITE returns the state to LOAD. The mask is kept, so changing one operand needs a single WRITE.
- Simultaneous events: bec_done and a command event in the same cycle are both processed. The command sees the pre-edge state, so a READ in RUN still flags err.
- Reset mid-RUN: returns to IDLE with results cleared. A later bec_done is ignored.
- err is sticky until CLEAR or an accepted START.
- All LA input bits whose la_oenb bit is 1 are treated as 0.

Test Plan:
- Reset, then 36 WRITEs covering sel 0..5, idx 0..5, with word 5 = 0xFFFFFFFF -> each bec_ops element top bits [162:160]=3'b111 with no other bits; ack_cnt=36; state=01; err=0.
- START after a full load -> bec_start high exactly 1 cycle, state=10, busy=1. Model pulses bec_done after 1000 cycles with bec_res element0=0x1 -> state=11, done=1. READ sel=7 returns 1000±1. READ sel0 idx0 returns 0x00000001.
- START with one mask word missing -> err=1, no bec_start, state unchanged. CLEAR -> err=0, mask=0.
- WRITE, then READ, during RUN -> err=1, operand regs unchanged. bec_done on the same cycle as the READ strobe -> DONE reached and err=1.
- Strobe held high for 10 cycles -> exactly one event; ack_cnt +1.
- Same WRITE with la_oenb[42]=1 -> no event. 256 events -> ack_cnt wraps to 0.
- Assert wb_rst_i during RUN, then pulse bec_done -> state stays 00 and results stay 0.
